// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  // Which requester a pending read response belongs to.
  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  // Default bound on how long the loader (m1) may be starved by the core (m0).
  localparam int MAX_WAIT_DEFAULT = 8;

  // Width of the starvation counter; MAX_WAIT must fit in it (1..255).
  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/ram_arb_if.sv
// One requester's access port: request/handshake plus read response.
interface ram_arb_if #(
  parameter int XLEN         = 32,
  parameter int RAM_ADDR_LEN = 14
);

  logic                    req;
  logic [XLEN/8-1:0]       we;
  logic [RAM_ADDR_LEN-1:0] addr;
  logic [XLEN-1:0]         wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [XLEN-1:0]         rdata;

  // Requester side.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_arb.sv
// Arbitrates the core data port (m0) and the UART loader (m1) onto a
// single-port RAM. m0 normally wins; m1 is guaranteed access after MAX_WAIT
// stalled cycles, and gets exclusive access while lock is high. Read data
// returns one cycle after the grant, routed by a registered owner tag.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RAM_ADDR_LEN = 14,
  parameter int MAX_WAIT     = MAX_WAIT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    lock,
  ram_arb_if.slave                m0,
  ram_arb_if.slave                m1,
  output logic                    ram_en,
  output logic [XLEN/8-1:0]       ram_we,
  output logic [RAM_ADDR_LEN-1:0] ram_addr,
  output logic [XLEN-1:0]         ram_wdata,
  input  logic [XLEN-1:0]         ram_rdata
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_CNT = WAIT_CNT_W'(MAX_WAIT);

  logic                  m0_gnt;
  logic                  m1_gnt;
  logic                  m0_rvalid;
  logic                  m1_rvalid;

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  pending_q,  pending_d;
  owner_e                owner_q,    owner_d;

  // Grant selection: combinational from requests, lock and the wait counter.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the ifs can leave it unassigned and infer a latch.
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    // Reset is asynchronous, so the grant is gated directly by rstb rather
    // than waiting for a clock edge to suppress it.
    if (rstb) begin
      if (lock) begin
        m1_gnt = m1.req;
      end else if ((wait_cnt_q == MAX_WAIT_CNT) && m1.req) begin
        m1_gnt = 1'b1;
      end else if (m0.req) begin
        m0_gnt = 1'b1;
      end else if (m1.req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  // RAM port A mux: command fields follow the granted requester.
  always_comb begin
    ram_en    = m0_gnt | m1_gnt;
    ram_we    = '0;
    ram_addr  = m0.addr;
    ram_wdata = m0.wdata;
    if (m1_gnt) begin
      ram_we    = m1.we;
      ram_addr  = m1.addr;
      ram_wdata = m1.wdata;
    end else if (m0_gnt) begin
      ram_we = m0.we;
    end
  end

  // Next state: starvation counter and the one-deep read response tag.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (lock || !m1.req || m1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_WAIT_CNT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // A new tag is captured every cycle, which keeps back-to-back reads of
    // mixed ownership aligned with the data the RAM returns.
    pending_d = ram_en && (ram_we == '0);
    owner_d   = m1_gnt ? OWN_M1 : OWN_M0;
  end

  // State registers; reset drops any in-flight read response.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wait_cnt_q <= '0;
      pending_q  <= 1'b0;
      owner_q    <= OWN_M0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
      owner_q    <= owner_d;
    end
  end

  // Response routing: only the tagged owner sees valid data, the other gets 0.
  always_comb begin
    m0_rvalid = pending_q && (owner_q == OWN_M0);
    m1_rvalid = pending_q && (owner_q == OWN_M1);
  end

  assign m0.gnt    = m0_gnt;
  assign m1.gnt    = m1_gnt;
  assign m0.rvalid = m0_rvalid;
  assign m1.rvalid = m1_rvalid;
  assign m0.rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1.rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter RAM_ADDR_LEN, default 14: RAM word-address width.
REQ-003 SHALL have parameter MAX_WAIT, default 8: maximum number of cycles m1 waits while m0 holds the port; legal range 1..255.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rstb  in  1  reset, asynchronous, active-low.
REQ-006 lock  in  1  when high, m1 has exclusive ownership (software upgrade in progress).
REQ-007 m0_req  in  1  core data-port access request; held until m0_gnt.
REQ-008 m0_we  in  XLEN/8  byte write enables; all zero means a read.
REQ-009 m0_addr  in  RAM_ADDR_LEN  word address.
REQ-010 m0_wdata  in  XLEN  write data.
REQ-011 m0_gnt  out  1  access accepted this cycle.
REQ-012 m0_rvalid  out  1  read data valid.
REQ-013 m0_rdata  out  XLEN  read data.
REQ-014 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata SHALL be identical to the m0_* ports, serving the UART loader requester.
REQ-015 ram_en  out  1; ram_we  out  XLEN/8; ram_addr  out  RAM_ADDR_LEN; ram_wdata  out  XLEN: single-port RAM port A.
REQ-016 ram_rdata  in  XLEN  RAM read data, valid one cycle after ram_en with ram_we == 0.

Function
REQ-017 SHALL grant at most one requester per cycle; grant SHALL be combinational from the current req, lock and state.
REQ-018 Arbitration order: lock=1 -> grant m1 only, never m0; else if wait_cnt == MAX_WAIT and m1_req -> grant m1; else if m0_req -> grant m0; else if m1_req -> grant m1.
REQ-019 ram_en SHALL equal (m0_gnt | m1_gnt); ram_we/ram_addr/ram_wdata SHALL be taken from the granted requester; when no grant, ram_we SHALL be 0.
REQ-020 wait_cnt (8 bit) SHALL increment when m1_req=1 and m1_gnt=0, and clear to 0 on m1_gnt or when m1_req=0; it SHALL saturate at MAX_WAIT.
REQ-021 A granted read (we == 0) SHALL set a registered owner tag and a pending flag; in the next cycle the owner's rvalid SHALL be 1 and its rdata SHALL equal ram_rdata; rdata of the other requester SHALL be 0.
REQ-022 Writes SHALL produce no rvalid; read latency SHALL be exactly 1 cycle, with back-to-back reads at full rate.
REQ-023 Reads of mixed ownership on consecutive cycles SHALL each return to the correct owner (tag pipelined per cycle).
REQ-024 lock rising while m0 read data is pending SHALL still deliver that m0_rvalid; m0_req SHALL wait without grant while lock=1.
REQ-025 lock SHALL clear wait_cnt to 0.
REQ-026 Simultaneous m0_req and m1_req with wait_cnt < MAX_WAIT and lock=0 SHALL grant m0.

Reset
REQ-027 On rstb low: m0_gnt=m1_gnt=0 (no requests are granted while in reset), m0_rvalid=m1_rvalid=0, rdata outputs=0, ram_en=0, ram_we=0, wait_cnt=0, pending=0, owner tag=m0.
REQ-028 Reset mid-read SHALL discard the pending response; no rvalid SHALL follow deassertion.

Structure
REQ-029 A shared package ram_arb_pkg SHALL hold the owner enum (OWN_M0, OWN_M1) and the default MAX_WAIT constant.
REQ-030 SHALL be flat: no sub-modules; the grant logic and the response pipeline reside in this module.

Verification
REQ-031 m0 read addr 0x10, RAM holds 0xDEADBEEF -> m0_gnt in cycle 0; m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 1; m1_rvalid=0.
REQ-032 m0_req held continuously, m1_req asserted, MAX_WAIT=8 -> m1_gnt in exactly the 9th cycle of waiting; m0 stalled that cycle; wait_cnt then 0.
REQ-033 lock=1, m1 writes we=0xF, addr 0x3FFF, data 0x12345678 while m0_req=1 -> only m1_gnt; ram_we=0xF; m0_gnt stays 0 until lock=0.
REQ-034 Alternating m0/m1 reads to addresses 1 and 2 on consecutive cycles -> m0 and m1 each receive their own data one cycle later, with no cross-delivery.
REQ-035 rstb asserted in the cycle after an m1 read grant -> m1_rvalid never asserts; after release all outputs are 0 until a new request.
REQ-036 m0 read granted, lock rises in the next cycle -> m0_rvalid still 1 in that cycle with the correct data.
